// File: rtl/ps2_pkg.sv
// Shared constants, receiver state type and key-mapping helpers for the PS/2 arrow-key receiver.
// Optional WASD mapping is enabled with `define PS2_WASD_EN.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_LEFT  = 2'd1;
    localparam logic [1:0] ACT_RIGHT = 2'd2;
    localparam logic [1:0] ACT_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_hit_t;

    function automatic key_hit_t map_arrow(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = ACT_UP;
        case (code)
            SC_UP:    r.idx = ACT_UP;
            SC_LEFT:  r.idx = ACT_LEFT;
            SC_RIGHT: r.idx = ACT_RIGHT;
            SC_DOWN:  r.idx = ACT_DOWN;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic key_hit_t map_wasd(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = ACT_UP;
        case (code)
            SC_W:    r.idx = ACT_UP;
            SC_A:    r.idx = ACT_LEFT;
            SC_D:    r.idx = ACT_RIGHT;
            SC_S:    r.idx = ACT_DOWN;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_arrow_rx_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, start/data/parity/stop FSM
// and a mid-frame watchdog. Emits each good byte with a one-cycle valid, or a one-cycle error.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       pixel_clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    rx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic fall, rx_bit, timeout;

    assign fall    = ~clk_sync_q[1] & clk_prev_q;
    assign rx_bit  = data_sync_q[1];
    assign timeout = (state_q != RX_IDLE) && !fall && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_d = rx_bit;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (rx_bit && (^{shift_q, parity_q})) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
        end

        // Counter value = cycles elapsed since the last detected edge; zero whenever idle.
        if (state_d == RX_IDLE) wd_cnt_d = '0;
        else if (fall)          wd_cnt_d = CW'(1);
        else                    wd_cnt_d = wd_cnt_q + CW'(1);
    end

    always_ff @(posedge pixel_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            wd_cnt_q    <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            wd_cnt_q    <= wd_cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = valid_q;
    assign frame_error_o = err_q;

endmodule

// File: rtl/ps2_arrow_rx.sv
// PS/2 arrow-key receiver top: decodes E0/F0-prefixed arrow make/break codes into held-key bits.
// `define PS2_WASD_EN adds W/A/S/D as independent held keys ORed onto the same directions.
module ps2_arrow_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] action,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .pixel_clk_i  (pixel_clk),
        .rst_i        (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_error_o(rx_err)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] arrow_q, arrow_d;
    key_hit_t   arrow_hit;

    assign arrow_hit = map_arrow(rx_byte);

`ifdef PS2_WASD_EN
    logic [3:0] wasd_q, wasd_d;
    key_hit_t   wasd_hit;

    assign wasd_hit = map_wasd(rx_byte);
`endif

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        arrow_d = arrow_q;
`ifdef PS2_WASD_EN
        wasd_d  = wasd_q;
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                // E0 also drops a pending F0, so F0 E0 <code> decodes as a make.
                SC_EXT: begin
                    ext_d = 1'b1;
                    brk_d = 1'b0;
                end
                SC_BRK: brk_d = 1'b1;
                default: begin
                    if (ext_q && arrow_hit.hit) arrow_d[arrow_hit.idx] = ~brk_q;
`ifdef PS2_WASD_EN
                    if (!ext_q && wasd_hit.hit) wasd_d[wasd_hit.idx] = ~brk_q;
`endif
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            arrow_q <= '0;
`ifdef PS2_WASD_EN
            wasd_q  <= '0;
`endif
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            arrow_q <= arrow_d;
`ifdef PS2_WASD_EN
            wasd_q  <= wasd_d;
`endif
        end
    end

`ifdef PS2_WASD_EN
    assign action = arrow_q | wasd_q;
`else
    assign action = arrow_q;
`endif

    assign scancode       = rx_byte;
    assign scancode_valid = rx_valid;
    assign frame_error    = rx_err;

endmodule

// File: tb/tb_ps2_arrow_rx.sv
// Directed bench for ps2_arrow_rx: bit-banged PS/2 frames with hand-computed expected outputs.
module tb_ps2_arrow_rx;

    localparam int unsigned TO = 200;

    logic       pixel_clk = 1'b0;
    logic       rst       = 1'b1;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic [3:0] action;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_error;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_arrow_rx #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .action        (action),
        .scancode      (scancode),
        .scancode_valid(scancode_valid),
        .frame_error   (frame_error)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) begin
        if (scancode_valid) valid_cnt++;
        if (frame_error) err_cnt++;
        if (scancode_valid && frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge pixel_clk);
        ps2_data = b;
        repeat (5) @(negedge pixel_clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge pixel_clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge pixel_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_parity);
        logic p;
        p = ~(^b);
        if (!good_parity) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        repeat (10) @(negedge pixel_clk);
    endtask

    int v0, e0, found;

    initial begin
        repeat (4) @(negedge pixel_clk);
        check("rst_action", 32'(action), 32'h0);
        check("rst_scancode", 32'(scancode), 32'h0);
        check("rst_valid", 32'(scancode_valid), 32'h0);
        check("rst_error", 32'(frame_error), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge pixel_clk);

        // Test 1: up make then break
        v0 = valid_cnt;
        send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
        check("t1_make", 32'(action), 32'h1);
        check("t1_make_valids", 32'(valid_cnt - v0), 32'd2);
        check("t1_scancode", 32'(scancode), 32'h75);
        v0 = valid_cnt;
        send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h75, 1'b1);
        check("t1_break", 32'(action), 32'h0);
        check("t1_break_valids", 32'(valid_cnt - v0), 32'd3);

        // Test 2: right + down held, then right released
        send_byte(8'hE0, 1'b1); send_byte(8'h74, 1'b1);
        check("t2_right", 32'(action), 32'h4);
        send_byte(8'hE0, 1'b1); send_byte(8'h72, 1'b1);
        check("t2_diag", 32'(action), 32'hC);
        send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h74, 1'b1);
        check("t2_release", 32'(action), 32'h8);

        // Test 3: parity error
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h75, 1'b0);
        check("t3_err", 32'(err_cnt - e0), 32'd1);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_action", 32'(action), 32'h8);
        check("t3_scancode_kept", 32'(scancode), 32'h74);

        // Test 4: timeout after 4 bits; last raw fall is 16 negedges before the loop's first sample,
        // detection lands 2 samples after the raw fall and the pulse TO cycles after detection.
        e0 = err_cnt; v0 = valid_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        found = -1;
        for (int i = 16; i < int'(TO) + 60; i++) begin
            @(negedge pixel_clk);
            if (frame_error && found < 0) found = i;
        end
        check("t4_timeout_lat", 32'(found), 32'(TO + 2));
        check("t4_timeout_cnt", 32'(err_cnt - e0), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_byte(8'hE0, 1'b1); send_byte(8'h6B, 1'b1);
        check("t4_left", 32'(action), 32'hA);

        // Non-extended keypad code is ignored
        send_byte(8'h75, 1'b1);
        check("kp_ignored", 32'(action), 32'hA);
        check("kp_scancode", 32'(scancode), 32'h75);

        // Test 5: reach 0101, then reset mid-frame
        send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h72, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h6B, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
        send_byte(8'hE0, 1'b1); send_byte(8'h74, 1'b1);
        check("t5_pre", 32'(action), 32'h5);
        send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        @(negedge pixel_clk);
        check("t5_rst_action", 32'(action), 32'h0);
        check("t5_rst_scancode", 32'(scancode), 32'h0);
        check("t5_rst_valid", 32'(scancode_valid), 32'h0);
        check("t5_rst_error", 32'(frame_error), 32'h0);
        repeat (2) @(negedge pixel_clk);
        rst = 1'b0;
        repeat (4) @(negedge pixel_clk);
        send_byte(8'hE0, 1'b1); send_byte(8'h72, 1'b1);
        check("t5_after", 32'(action), 32'h8);
        check("t5_after_sc", 32'(scancode), 32'h72);

        // Test 6: WASD
`ifdef PS2_WASD_EN
        send_byte(8'h1D, 1'b1);
        check("t6_w", 32'(action), 32'h9);
        send_byte(8'hE0, 1'b1); send_byte(8'h75, 1'b1);
        check("t6_w_up", 32'(action), 32'h9);
        send_byte(8'hF0, 1'b1); send_byte(8'h1D, 1'b1);
        check("t6_w_rel", 32'(action), 32'h9);
`else
        send_byte(8'h1D, 1'b1);
        check("t6_w_ignored", 32'(action), 32'h8);
        check("t6_w_sc", 32'(scancode), 32'h1D);
`endif

        check("never_both", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
